// File: rtl/seq_detect_param.sv
// Runtime-programmable serial sequence detector: shift-and-compare against a loadable pattern,
// registered (Moore) match flag and saturating match counter.
module seq_detect_param #(
  parameter int unsigned        PAT_LEN   = 4,
  parameter int unsigned        CNT_W     = 8,
  parameter logic [PAT_LEN-1:0] RESET_PAT = PAT_LEN'(4'b1011)
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               in,
  input  logic               in_valid,
  input  logic               overlap,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pattern,
  output logic               out,
  output logic [CNT_W-1:0]   match_count
);

  localparam int unsigned      FillW   = $clog2(PAT_LEN + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_LEN-1:0] window;
  logic               accept;
  logic               match;

  always_comb begin
    // Oldest history bit lines up with pattern MSB, the incoming bit with pattern LSB.
    window = {hist_q, in};
    accept = in_valid & ~load;
    match  = (fill_q == FillMax) && (window == pat_q);

    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = out_q;
    cnt_d  = cnt_q;

    if (load) begin
      pat_d  = pattern;
      fill_d = '0;
      out_d  = 1'b0;
    end else if (accept) begin
      hist_d = window[PAT_LEN-2:0];
      out_d  = match;
      if (match && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (match && !overlap) begin
        fill_d = '0;
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + FillW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      pat_q  <= RESET_PAT;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: a reference model feeds a scoreboard checked every cycle,
// plus per-scenario checks against hand-derived values.
module tb_seq_detect_param;

  logic       clk;
  logic       clear;
  logic       in;
  logic       in_valid;
  logic       overlap;
  logic       load;
  logic [3:0] pattern;
  logic       out_a;
  logic [7:0] cnt_a;
  logic       out_s;
  logic [1:0] cnt_s;

  int errors = 0;
  int checks = 0;
  logic cur_ov = 1'b1;

  typedef struct packed {
    logic       o;
    logic [7:0] c;
    logic [1:0] c2;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state
  logic [3:0] m_pat;
  logic [2:0] m_hist;
  int         m_fill;
  logic       m_out;
  int         m_cnt;
  int         m_cnt2;

  seq_detect_param #(.PAT_LEN(4), .CNT_W(8), .RESET_PAT(4'b1011)) u_dut (
    .clk        (clk),
    .clear      (clear),
    .in         (in),
    .in_valid   (in_valid),
    .overlap    (overlap),
    .load       (load),
    .pattern    (pattern),
    .out        (out_a),
    .match_count(cnt_a)
  );

  seq_detect_param #(.PAT_LEN(4), .CNT_W(2), .RESET_PAT(4'b1011)) u_sat (
    .clk        (clk),
    .clear      (clear),
    .in         (in),
    .in_valid   (in_valid),
    .overlap    (overlap),
    .load       (load),
    .pattern    (pattern),
    .out        (out_s),
    .match_count(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: one expected entry per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (out_a !== e.o || cnt_a !== e.c || out_s !== e.o || cnt_s !== e.c2) begin
        errors++;
        $display("FAIL scoreboard @%0t: out=%0b cnt=%0d out2=%0b cnt2=%0d expected out=%0b cnt=%0d cnt2=%0d",
                 $time, out_a, cnt_a, out_s, cnt_s, e.o, e.c, e.c2);
      end
    end
  end

  task automatic step(input logic c, input logic ld, input logic v, input logic b,
                      input logic ov, input logic [3:0] p);
    exp_t e;
    logic mt;
    clear = c; load = ld; in_valid = v; in = b; overlap = ov; pattern = p;
    if (c) begin
      m_pat = 4'b1011; m_hist = '0; m_fill = 0; m_out = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end else if (ld) begin
      m_pat = p; m_fill = 0; m_out = 1'b0;
    end else if (v) begin
      mt     = (m_fill == 3) && ({m_hist, b} == m_pat);
      m_hist = {m_hist[1:0], b};
      m_out  = mt;
      if (mt) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (mt && !ov) m_fill = 0;
      else if (m_fill < 3) m_fill++;
    end
    e.o  = m_out;
    e.c  = 8'(m_cnt);
    e.c2 = 2'(m_cnt2);
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic do_clear();
    step(1'b1, 1'b0, 1'b0, 1'b0, cur_ov, 4'b0000);
  endtask

  task automatic do_load(input logic [3:0] p, input logic v, input logic b);
    step(1'b0, 1'b1, v, b, cur_ov, p);
  endtask

  task automatic bit_in(input logic b);
    step(1'b0, 1'b0, 1'b1, b, cur_ov, 4'b0000);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b1, cur_ov, 4'b0000);
  endtask

  // Feeds n bits MSB-first and records out after each, first bit's result in the MSB.
  task automatic feed(input logic [15:0] bits, input int n, output logic [15:0] outs);
    outs = '0;
    for (int i = 0; i < n; i++) begin
      bit_in(bits[n-1-i]);
      outs[n-1-i] = out_a;
    end
  endtask

  task automatic test_reset();
    do_clear();
    checks++;
    if (out_a !== 1'b0 || cnt_a !== 8'd0) begin
      errors++; $display("FAIL reset_outputs: out=%0b cnt=%0d expected 0/0", out_a, cnt_a);
    end
    checks++;
    if (u_dut.pat_q !== 4'b1011) begin
      errors++; $display("FAIL reset_pattern: pat=%b expected 1011", u_dut.pat_q);
    end
  endtask

  task automatic test_overlap();
    logic [15:0] o;
    cur_ov = 1'b1;
    do_clear();
    feed(16'b1011011, 7, o);
    checks++;
    if (o !== 16'b0001001) begin
      errors++; $display("FAIL overlap_outs: out=%b expected 0001001", o[6:0]);
    end
    checks++;
    if (cnt_a !== 8'd2) begin
      errors++; $display("FAIL overlap_count: cnt=%0d expected 2", cnt_a);
    end
  endtask

  task automatic test_non_overlap();
    logic [15:0] o;
    cur_ov = 1'b0;
    do_clear();
    feed(16'b1011011, 7, o);
    checks++;
    if (o !== 16'b0001000 || cnt_a !== 8'd1) begin
      errors++; $display("FAIL nonoverlap_a: out=%b cnt=%0d expected 0001000/1", o[6:0], cnt_a);
    end
    do_clear();
    feed(16'b10111011, 8, o);
    checks++;
    if (o !== 16'b00010001 || cnt_a !== 8'd2) begin
      errors++; $display("FAIL nonoverlap_b: out=%b cnt=%0d expected 00010001/2", o[7:0], cnt_a);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] s;
    s = 4'b1011;
    cur_ov = 1'b1;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      bit_in(s[3-i]);
      repeat (3) idle();
    end
    checks++;
    if (out_a !== 1'b1 || cnt_a !== 8'd1) begin
      errors++; $display("FAIL gaps_hold: out=%0b cnt=%0d expected 1/1", out_a, cnt_a);
    end
    bit_in(1'b0);
    checks++;
    if (out_a !== 1'b0) begin
      errors++; $display("FAIL gaps_fall: out=%0b expected 0", out_a);
    end
  endtask

  task automatic test_load();
    logic [15:0] o;
    cur_ov = 1'b1;
    do_load(4'b1111, 1'b0, 1'b0);
    checks++;
    if (out_a !== 1'b0 || cnt_a !== 8'd1 || u_dut.pat_q !== 4'b1111) begin
      errors++; $display("FAIL load_apply: out=%0b cnt=%0d pat=%b expected 0/1/1111",
                         out_a, cnt_a, u_dut.pat_q);
    end
    feed(16'b111111, 6, o);
    checks++;
    if (o !== 16'b000111 || cnt_a !== 8'd4) begin
      errors++; $display("FAIL load_ones: out=%b cnt=%0d expected 000111/4", o[5:0], cnt_a);
    end
    do_load(4'b1111, 1'b1, 1'b1);
    feed(16'b1111, 4, o);
    checks++;
    if (o !== 16'b0001) begin
      errors++; $display("FAIL load_drop: out=%b expected 0001", o[3:0]);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] o;
    logic [1:0] exp_c [5];
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    cur_ov = 1'b1;
    do_clear();
    for (int k = 0; k < 5; k++) begin
      feed(16'b1011, 4, o);
      checks++;
      if (cnt_s !== exp_c[k] || out_s !== 1'b1) begin
        errors++; $display("FAIL saturate_%0d: cnt2=%0d out2=%0b expected %0d/1",
                           k, cnt_s, out_s, exp_c[k]);
      end
    end
    checks++;
    if (cnt_a !== 8'd5) begin
      errors++; $display("FAIL saturate_wide: cnt=%0d expected 5", cnt_a);
    end
  endtask

  task automatic test_clear_mid();
    logic [15:0] o;
    cur_ov = 1'b1;
    do_load(4'b0110, 1'b0, 1'b0);
    feed(16'b0110, 4, o);
    feed(16'b101, 3, o);
    do_clear();
    checks++;
    if (cnt_a !== 8'd0 || out_a !== 1'b0 || u_dut.pat_q !== 4'b1011) begin
      errors++; $display("FAIL clear_mid: cnt=%0d out=%0b pat=%b expected 0/0/1011",
                         cnt_a, out_a, u_dut.pat_q);
    end
    bit_in(1'b1);
    checks++;
    if (out_a !== 1'b0 || cnt_a !== 8'd0) begin
      errors++; $display("FAIL clear_nomatch: out=%0b cnt=%0d expected 0/0", out_a, cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] o;
    cur_ov = 1'b0;
    do_clear();
    do_load(4'b1111, 1'b0, 1'b0);
    feed(16'b11111111, 8, o);
    checks++;
    if (o !== 16'b00010001 || cnt_a !== 8'd2) begin
      errors++; $display("FAIL b2b_nonoverlap: out=%b cnt=%0d expected 00010001/2", o[7:0], cnt_a);
    end
    cur_ov = 1'b1;
    feed(16'b1111, 4, o);
    cur_ov = 1'b0;
    bit_in(1'b1);
    checks++;
    if (out_a !== 1'b1) begin
      errors++; $display("FAIL b2b_ovswitch_hit: out=%0b expected 1", out_a);
    end
    bit_in(1'b1);
    checks++;
    if (out_a !== 1'b0 || cnt_a !== 8'd4) begin
      errors++; $display("FAIL b2b_ovswitch_restart: out=%0b cnt=%0d expected 0/4", out_a, cnt_a);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_gaps();
    test_load();
    test_saturate();
    test_clear_mid();
    test_back_to_back();
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: pending=%0d expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised, runtime-programmable serial sequence detector with a Moore-style registered match output. It consumes one qualified serial bit per clock and flags when the most recent PAT_LEN accepted bits equal a programmable pattern. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits alongside the fixed-pattern FSM detectors and replaces them wherever pattern, length or overlap mode must be configurable.

## Interface
- PAT_LEN, 4: pattern length in bits; legal range 2..16.
- CNT_W, 8: width of the match counter.
- RESET_PAT, 4'b1011: pattern register value after `clear`; PAT_LEN bits wide.

- clk  input  1  clock; all state updates on its rising edge.
- clear  input  1  reset, synchronous and active-high.
- in  input  1  serial data bit.
- in_valid  input  1  qualifies `in`; a bit is accepted on an edge where in_valid=1, load=0 and clear=0.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled on every accepted bit.
- load  input  1  pattern load strobe.
- pattern  input  PAT_LEN  new pattern; captured when load=1.
- out  output  1  match flag, driven only from registered state (Moore).
- match_count  output  CNT_W  number of matches since clear; saturates at all-ones.

## Operation
- Bit order: pattern[PAT_LEN-1] is the first bit received and pattern[0] is the last. With pattern 4'b1011, the detector matches the input sequence 1,0,1,1.
- State registers:
  - pat_q: PAT_LEN bits.
  - hist: PAT_LEN-1 bits, most recent accepted bits, newest in bit 0.
  - fill: clog2(PAT_LEN+1) bits, count of valid history bits, saturating at PAT_LEN-1.
  - out, match_count.
- Match condition on an accepted bit: fill == PAT_LEN-1 and {hist, in} == pat_q.
- On an accepted bit:
  - The bit shifts into hist.
  - out takes the match condition.
  - On a match, match_count increments unless it is all-ones.
  - On a match with overlap=0, fill returns to 0.
  - Otherwise fill increments, saturating at PAT_LEN-1.
- When no bit is accepted and there is no load, all state holds, including out. out therefore stays high until the next accepted bit, load, or clear.
- load=1 (and clear=0):
  - pat_q takes `pattern`.
  - fill returns to 0 and out goes to 0.
  - hist contents are don't-care.
  - match_count holds.
  - A bit presented with in_valid in the same cycle is discarded.
- clear=1 overrides everything:
  - pat_q takes RESET_PAT.
  - fill, hist, out and match_count all go to 0.
- Conceptual states are the fill values 0..PAT_LEN-1 plus the MATCH indication held in out. The implementation uses shift-and-compare rather than a hand-coded state graph.
- Patterns with self-overlap, e.g. 1111: with overlap=1, every accepted 1 after the fourth consecutive 1 matches.

## Timing
- Reset values: out=0, match_count=0, pat_q=RESET_PAT, fill=0.
- Latency: out rises on the same clock edge that accepts the completing bit. It is visible in the cycle after that bit was presented, which gives exactly one cycle of latency.
- With continuous in_valid=1, out is high for exactly one cycle per match.
- match_count updates on the same edge as out.
- clear or load mid-sequence takes effect at that edge and discards partial progress. The earliest next match is PAT_LEN accepted bits later.
- Changing `overlap` affects only the match decision for the bit accepted on that edge. Partial progress is not cleared.
- No combinational path from any input to any output.

## Test plan
- After clear, pattern 1011, overlap=1, in_valid=1, stream 1,0,1,1,0,1,1 -> out high in the cycles after bits 4 and 7; match_count=2.
- Same stream with overlap=0 -> out high only after bit 4; match_count=1. Stream 1,0,1,1,1,0,1,1 -> matches after bits 4 and 8.
- in_valid gaps: stream 1,0,1,1 with in_valid low for 3 cycles between each bit -> single match after bit 4. out holds high until the next accepted bit, then falls if there is no match.
- load pattern 4'b1111, overlap=1, feed six 1s -> out high after bits 4, 5 and 6. Asserting load together with in_valid in the middle of the stream -> that bit is dropped and fill restarts from 0.
- CNT_W=2, pattern 1011, overlap=1, repeated 1011 ×5 -> match_count goes 1, 2, 3, 3, 3 (saturates).
- clear asserted mid-pattern after 1,0,1, then bit 1 -> no match. match_count=0 and pat_q reverts to RESET_PAT.
